// File: rtl/snn_pkg.sv
// Shared constants and saturation helper for the SNN datapaths (synapse and LIF neuron).
package snn_pkg;

    localparam int NBITS_DEFAULT = 6;

    localparam logic signed [NBITS_DEFAULT-1:0] SAT_MAX = {1'b0, {(NBITS_DEFAULT-1){1'b1}}};
    localparam logic signed [NBITS_DEFAULT-1:0] SAT_MIN = {1'b1, {(NBITS_DEFAULT-1){1'b0}}};

    // Two guard bits give enough headroom for one decayed value plus one weight.
    localparam logic signed [NBITS_DEFAULT+1:0] SAT_MAX_WIDE = (NBITS_DEFAULT+2)'(SAT_MAX);
    localparam logic signed [NBITS_DEFAULT+1:0] SAT_MIN_WIDE = (NBITS_DEFAULT+2)'(SAT_MIN);

    typedef struct packed {
        logic signed [NBITS_DEFAULT-1:0] value;
        logic                            overflow;
    } sat_result_t;

    // Clamp a widened sum into the NBITS range and report whether clamping happened.
    function automatic sat_result_t sat_nbits(input logic signed [NBITS_DEFAULT+1:0] x);
        sat_result_t r;
        if (x > SAT_MAX_WIDE) begin
            r.value    = SAT_MAX;
            r.overflow = 1'b1;
        end else if (x < SAT_MIN_WIDE) begin
            r.value    = SAT_MIN;
            r.overflow = 1'b1;
        end else begin
            r.value    = x[NBITS_DEFAULT-1:0];
            r.overflow = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_delay_line.sv
// Axonal delay: shift register of past spikes with a selectable tap.
// A delay of zero bypasses the register and presents the live spike.
module spike_delay_line #(
    parameter int DELAY_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               spike_in,
    input  logic [DELAY_W-1:0] delay,
    output logic               spike_delayed
);

    localparam int STAGES = (2 ** DELAY_W) - 1;

    logic [STAGES-1:0]  sr;
    logic [DELAY_W-1:0] tap_idx;

    // Shift the spike history one stage per enabled cycle; reset discards in-flight spikes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (enable) begin
            sr <= {sr[STAGES-2:0], spike_in};
        end
    end

    // Select the live spike or the stage matching the requested delay.
    always_comb begin
        tap_idx = delay - 1'b1;
        if (delay == '0) begin
            spike_delayed = spike_in;
        end else begin
            spike_delayed = sr[tap_idx];
        end
    end

endmodule

// File: rtl/synapse_current_driver.sv
// Synaptic current driver: delayed spikes add their weight to a current register
// that decays toward zero each enabled cycle, saturating to the signed NBITS range.
module synapse_current_driver
    import snn_pkg::*;
#(
    parameter int NBITS   = NBITS_DEFAULT,
    parameter int DELAY_W = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    spike_in,
    input  logic signed [NBITS-1:0] weight,
    input  logic signed [NBITS-1:0] decay,
    input  logic [DELAY_W-1:0]      delay,
    output logic                    spike_delayed,
    output logic signed [NBITS-1:0] current_out,
    output logic                    active,
    output logic                    sat_out
);

    localparam int W = NBITS + 2;

    logic signed [W-1:0] c_w;
    logic signed [W-1:0] d_w;
    logic signed [W-1:0] cd_w;
    logic signed [W-1:0] w_w;
    logic signed [W-1:0] n_w;
    sat_result_t         sat_r;

    spike_delay_line #(
        .DELAY_W(DELAY_W)
    ) u_delay_line (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .spike_in     (spike_in),
        .delay        (delay),
        .spike_delayed(spike_delayed)
    );

    // Decay toward zero without crossing it, then add the weight of any delayed spike.
    always_comb begin
        c_w = {{2{current_out[NBITS-1]}}, current_out};
        d_w = decay[NBITS-1] ? '0 : {2'b00, decay};
        w_w = spike_delayed ? {{2{weight[NBITS-1]}}, weight} : '0;
        if (c_w > 0) begin
            cd_w = c_w - ((d_w < c_w) ? d_w : c_w);
        end else if (c_w < 0) begin
            cd_w = c_w + ((d_w < -c_w) ? d_w : -c_w);
        end else begin
            cd_w = '0;
        end
        n_w   = cd_w + w_w;
        sat_r = sat_nbits(n_w);
    end

    // Commit the saturated current and its status flags on each enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_out <= '0;
            active      <= 1'b0;
            sat_out     <= 1'b0;
        end else if (enable) begin
            current_out <= sat_r.value;
            active      <= (sat_r.value != '0);
            sat_out     <= sat_r.overflow;
        end
    end

endmodule

// File: tb/tb_synapse_current_driver.sv
// Directed and model-based checks for the synapse current driver (NBITS=6, DELAY_W=3).
module tb_synapse_current_driver;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              spike_in;
    logic signed [5:0] weight;
    logic signed [5:0] decay;
    logic [2:0]        delay;
    logic              spike_delayed;
    logic signed [5:0] current_out;
    logic              active;
    logic              sat_out;

    int errors = 0;
    int checks = 0;

    synapse_current_driver #(
        .NBITS  (6),
        .DELAY_W(3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .spike_in     (spike_in),
        .weight       (weight),
        .decay        (decay),
        .delay        (delay),
        .spike_delayed(spike_delayed),
        .current_out  (current_out),
        .active       (active),
        .sat_out      (sat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        spike_in = 1'b0;
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; enable = 1'b1; delay = 3'd0; weight = 6'sd10; decay = 6'sd0;
        spike_in = 1'b1;
        tick();
        tick();
        checks++;
        if (current_out !== 6'sd20) begin
            errors++;
            $display("FAIL reset_preload current_out=%0d expected=20", current_out);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (current_out !== 6'sd0 || active !== 1'b0 || sat_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async current_out=%0d active=%b sat_out=%b expected=0/0/0",
                     current_out, active, sat_out);
        end
        spike_in = 1'b0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (current_out !== 6'sd0 || active !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d current_out=%0d active=%b expected=0/0",
                         i, current_out, active);
            end
        end
    endtask

    task automatic test_delay();
        int exp_d[5] = '{0, 0, 0, 10, 10};
        pulse_reset();
        enable = 1'b1; delay = 3'd3; weight = 6'sd10; decay = 6'sd0;
        tick();
        spike_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            spike_in = 1'b0;
            if (i == 2) begin
                checks++;
                if (spike_delayed !== 1'b1) begin
                    errors++;
                    $display("FAIL delay3_tap spike_delayed=%b expected=1", spike_delayed);
                end
            end
            checks++;
            if (current_out !== 6'(exp_d[i])) begin
                errors++;
                $display("FAIL delay3 edge=k+%0d current_out=%0d expected=%0d",
                         i, current_out, exp_d[i]);
            end
        end
        pulse_reset();
        delay = 3'd0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        checks++;
        if (current_out !== 6'sd10 || active !== 1'b1) begin
            errors++;
            $display("FAIL delay0 current_out=%0d active=%b expected=10/1", current_out, active);
        end
    endtask

    task automatic test_decay();
        int exp_pos[5] = '{14, 8, 2, 0, 0};
        int exp_neg[4] = '{-14, -8, -2, 0};
        pulse_reset();
        enable = 1'b1; delay = 3'd0; weight = 6'sd20; decay = 6'sd0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0; decay = 6'sd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (current_out !== 6'(exp_pos[i]) || active !== (exp_pos[i] != 0)) begin
                errors++;
                $display("FAIL decay_pos step=%0d current_out=%0d active=%b expected=%0d",
                         i, current_out, active, exp_pos[i]);
            end
        end
        pulse_reset();
        weight = -6'sd20; decay = 6'sd0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0; decay = 6'sd6;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (current_out !== 6'(exp_neg[i])) begin
                errors++;
                $display("FAIL decay_neg step=%0d current_out=%0d expected=%0d",
                         i, current_out, exp_neg[i]);
            end
        end
        pulse_reset();
        decay = -6'sd3;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (current_out !== -6'sd20) begin
                errors++;
                $display("FAIL decay_negative_hold step=%0d current_out=%0d expected=-20",
                         i, current_out);
            end
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        enable = 1'b1; delay = 3'd0; weight = 6'sd25; decay = 6'sd0;
        spike_in = 1'b1;
        tick();
        checks++;
        if (current_out !== 6'sd25 || sat_out !== 1'b0) begin
            errors++;
            $display("FAIL sat_pos_first current_out=%0d sat_out=%b expected=25/0", current_out, sat_out);
        end
        tick();
        spike_in = 1'b0;
        checks++;
        if (current_out !== 6'sd31 || sat_out !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos current_out=%0d sat_out=%b expected=31/1", current_out, sat_out);
        end
        tick();
        checks++;
        if (current_out !== 6'sd31 || sat_out !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear current_out=%0d sat_out=%b expected=31/0", current_out, sat_out);
        end
        pulse_reset();
        weight = -6'sd30;
        spike_in = 1'b1;
        tick();
        checks++;
        if (current_out !== -6'sd30 || sat_out !== 1'b0) begin
            errors++;
            $display("FAIL sat_neg_first current_out=%0d sat_out=%b expected=-30/0", current_out, sat_out);
        end
        tick();
        spike_in = 1'b0;
        checks++;
        if (current_out !== -6'sd32 || sat_out !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg current_out=%0d sat_out=%b expected=-32/1", current_out, sat_out);
        end
    endtask

    task automatic test_enable_gating();
        pulse_reset();
        enable = 1'b1; delay = 3'd0; weight = 6'sd10; decay = 6'sd0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        tick();
        delay = 3'd1;
        for (int i = 0; i < 10; i++) begin
            enable   = (i % 2) == 1;
            spike_in = (i % 2) == 0;
            tick();
            checks++;
            if (current_out !== 6'sd10 || spike_delayed !== 1'b0) begin
                errors++;
                $display("FAIL enable_gating cycle=%0d current_out=%0d spike_delayed=%b expected=10/0",
                         i, current_out, spike_delayed);
            end
        end
        spike_in = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_random();
        int msr[7];
        int mcur;
        int mact;
        int msat;
        int tap;
        int dd;
        int cd;
        int n;
        int w;
        pulse_reset();
        for (int i = 0; i < 7; i++) msr[i] = 0;
        mcur = 0; mact = 0; msat = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            enable   = ($urandom_range(0, 3) != 0);
            spike_in = $urandom_range(0, 1) == 1;
            weight   = 6'($urandom_range(0, 63));
            decay    = 6'($urandom_range(0, 63));
            delay    = 3'($urandom_range(0, 7));
            if (enable) begin
                tap = (delay == 3'd0) ? int'(spike_in) : msr[int'(delay) - 1];
                w   = int'(weight);
                dd  = (int'(decay) < 0) ? 0 : int'(decay);
                if (mcur > 0)      cd = mcur - ((dd < mcur) ? dd : mcur);
                else if (mcur < 0) cd = mcur + ((dd < -mcur) ? dd : -mcur);
                else               cd = 0;
                n    = cd + ((tap != 0) ? w : 0);
                msat = (n > 31 || n < -32) ? 1 : 0;
                mcur = (n > 31) ? 31 : (n < -32) ? -32 : n;
                mact = (mcur != 0) ? 1 : 0;
                for (int s = 6; s > 0; s--) msr[s] = msr[s-1];
                msr[0] = int'(spike_in);
            end
            tick();
            checks++;
            if (int'(current_out) != mcur || int'(active) != mact || int'(sat_out) != msat) begin
                errors++;
                $display("FAIL random cycle=%0d current_out=%0d active=%b sat_out=%b expected=%0d/%0d/%0d",
                         cyc, current_out, active, sat_out, mcur, mact, msat);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; spike_in = 1'b0;
        weight = '0; decay = '0; delay = '0;
        repeat (2) tick();
        checks++;
        if (current_out !== 6'sd0 || active !== 1'b0 || sat_out !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset current_out=%0d active=%b sat_out=%b expected=0/0/0",
                     current_out, active, sat_out);
        end
        test_reset();
        test_delay();
        test_decay();
        test_saturation();
        test_enable_gating();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
